// File: rtl/neotang_uart_pkg.sv
// Shared definitions for the host-link command receiver.
//   CMD_*        command byte codes understood by the parser
//   rx_state_t   states of the serial bit receiver
//   par_state_t  states of the command parser
package neotang_uart_pkg;

    localparam logic [7:0] CMD_JOY_BASE    = 8'h01;
    localparam logic [7:0] CMD_OSD_ENABLE  = 8'h06;
    localparam logic [7:0] CMD_OSD_DISABLE = 8'h07;
    localparam logic [7:0] CMD_OSD_DATA    = 8'h08;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        P_IDLE,
        P_PAYLOAD
    } par_state_t;

endpackage

// File: rtl/neotang_uart_rx.sv
// 8N1 serial byte receiver with a 2-FF input synchroniser.
//   clk, reset  system clock, synchronous active-high reset
//   uart_rx     asynchronous serial input, idle high
//   rx_stb      one-clk strobe: rx_byte holds a byte with a good stop bit
//   rx_byte     last received byte (stable until the next rx_stb)
//   rx_ferr     one-clk strobe: a byte was dropped because its stop bit was 0
// rx_stb and rx_ferr are fire-and-forget strobes: there is no ready, the
// consumer must take the byte in the cycle rx_stb is high.
module neotang_uart_rx
    import neotang_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 90
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       rx_stb,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q, state_d;
    logic             meta_q, sync_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             stb_q, stb_d;
    logic [7:0]       byte_q, byte_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        stb_d   = 1'b0;
        byte_d  = byte_q;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Start on a falling edge only, so a line stuck low after a
                // bad stop bit does not retrigger.
                if (prev_q && !sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    if (sync_q) begin
                        stb_d  = 1'b1;
                        byte_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stb_q   <= 1'b0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            meta_q  <= uart_rx;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stb_q   <= stb_d;
            byte_q  <= byte_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_stb  = stb_q;
    assign rx_byte = byte_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/neotang_uart_cmd_rx.sv
// Host-link front end: decodes framed MCU commands from uart_rx into joystick
// words, an OSD enable flag and OSD pixel strobes, with error counters.
//   clk, reset     system clock, synchronous active-high reset
//   uart_rx        asynchronous serial input, idle high, 8N1
//   joy            NUM_JOY joystick words, channel n at [n*JOY_W +: JOY_W]
//   joy_upd        one-clk pulse per channel when its word is committed
//   osd_en         OSD overlay enable
//   osd_rgb        {R,G,B} of the last OSD pixel
//   osd_pix_valid  one-clk strobe, osd_rgb new this cycle
//   frame_err_cnt  saturating count of bytes with a bad stop bit
//   bad_cmd_cnt    saturating count of unknown command bytes
//   timeout_cnt    saturating count of aborted partial frames
module neotang_uart_cmd_rx
    import neotang_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 90,
    parameter int NUM_JOY      = 2,
    parameter int JOY_W        = 16,
    parameter int TIMEOUT_CLKS = 270000,
    parameter int CNT_W        = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     uart_rx,
    output logic [NUM_JOY*JOY_W-1:0] joy,
    output logic [NUM_JOY-1:0]       joy_upd,
    output logic                     osd_en,
    output logic [23:0]              osd_rgb,
    output logic                     osd_pix_valid,
    output logic [CNT_W-1:0]         frame_err_cnt,
    output logic [CNT_W-1:0]         bad_cmd_cnt,
    output logic [CNT_W-1:0]         timeout_cnt
);

    localparam int PAY_BYTES = JOY_W / 8;
    // Staging register fits either payload; bytes enter at the top so the
    // last N bytes always sit top-aligned with the first byte lowest.
    localparam int STG_W  = (JOY_W > 24) ? JOY_W : 24;
    localparam int IDLE_W = $clog2(TIMEOUT_CLKS + 1);

    logic       rx_stb;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    neotang_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .rx_stb  (rx_stb),
        .rx_byte (rx_byte),
        .rx_ferr (rx_ferr)
    );

    par_state_t               state_q, state_d;
    logic [2:0]               tgt_q, tgt_d;
    logic                     is_osd_q, is_osd_d;
    logic [7:0]               need_q, need_d;
    logic [STG_W-1:0]         stage_q, stage_d;
    logic                     commit_q, commit_d;
    logic [IDLE_W-1:0]        idle_q, idle_d;
    logic [NUM_JOY*JOY_W-1:0] joy_q, joy_d;
    logic [NUM_JOY-1:0]       joy_upd_q, joy_upd_d;
    logic                     osd_en_q, osd_en_d;
    logic [23:0]              osd_rgb_q, osd_rgb_d;
    logic                     pix_q, pix_d;
    logic [CNT_W-1:0]         ferr_cnt_q, ferr_cnt_d;
    logic [CNT_W-1:0]         bad_cnt_q, bad_cnt_d;
    logic [CNT_W-1:0]         to_cnt_q, to_cnt_d;
    logic [23:0]              osd_word;
    logic [JOY_W-1:0]         joy_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign osd_word = stage_q[STG_W-1 -: 24];
    assign joy_word = stage_q[STG_W-1 -: JOY_W];

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        is_osd_d   = is_osd_q;
        need_d     = need_q;
        stage_d    = stage_q;
        commit_d   = 1'b0;
        idle_d     = '0;
        joy_d      = joy_q;
        joy_upd_d  = '0;
        osd_en_d   = osd_en_q;
        osd_rgb_d  = osd_rgb_q;
        pix_d      = 1'b0;
        ferr_cnt_d = ferr_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        to_cnt_d   = to_cnt_q;

        // Commit lands one clk after the last payload byte's strobe.
        if (commit_q) begin
            if (is_osd_q) begin
                osd_rgb_d = {osd_word[7:0], osd_word[15:8], osd_word[23:16]};
                pix_d     = 1'b1;
            end else begin
                for (int n = 0; n < NUM_JOY; n++) begin
                    if (tgt_q == 3'(n)) begin
                        joy_d[n*JOY_W +: JOY_W] = joy_word;
                        joy_upd_d[n]            = 1'b1;
                    end
                end
            end
        end

        if (rx_ferr) ferr_cnt_d = sat_inc(ferr_cnt_q);

        case (state_q)
            P_IDLE: begin
                if (rx_stb) begin
                    if (rx_byte >= CMD_JOY_BASE && rx_byte <= 8'(NUM_JOY)) begin
                        tgt_d    = 3'(rx_byte - CMD_JOY_BASE);
                        is_osd_d = 1'b0;
                        need_d   = 8'(PAY_BYTES);
                        state_d  = P_PAYLOAD;
                    end else if (rx_byte == CMD_OSD_ENABLE) begin
                        osd_en_d = 1'b1;
                    end else if (rx_byte == CMD_OSD_DISABLE) begin
                        osd_en_d = 1'b0;
                    end else if (rx_byte == CMD_OSD_DATA) begin
                        is_osd_d = 1'b1;
                        need_d   = 8'd3;
                        state_d  = P_PAYLOAD;
                    end else begin
                        bad_cnt_d = sat_inc(bad_cnt_q);
                    end
                end
            end
            P_PAYLOAD: begin
                if (rx_stb) begin
                    stage_d = {rx_byte, stage_q[STG_W-1:8]};
                    need_d  = need_q - 1'b1;
                    if (need_q == 8'd1) begin
                        commit_d = 1'b1;
                        state_d  = P_IDLE;
                    end
                end else if (idle_q == IDLE_W'(TIMEOUT_CLKS - 1)) begin
                    stage_d  = '0;
                    to_cnt_d = sat_inc(to_cnt_q);
                    state_d  = P_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= P_IDLE;
            tgt_q      <= '0;
            is_osd_q   <= 1'b0;
            need_q     <= '0;
            stage_q    <= '0;
            commit_q   <= 1'b0;
            idle_q     <= '0;
            joy_q      <= '0;
            joy_upd_q  <= '0;
            osd_en_q   <= 1'b0;
            osd_rgb_q  <= '0;
            pix_q      <= 1'b0;
            ferr_cnt_q <= '0;
            bad_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            is_osd_q   <= is_osd_d;
            need_q     <= need_d;
            stage_q    <= stage_d;
            commit_q   <= commit_d;
            idle_q     <= idle_d;
            joy_q      <= joy_d;
            joy_upd_q  <= joy_upd_d;
            osd_en_q   <= osd_en_d;
            osd_rgb_q  <= osd_rgb_d;
            pix_q      <= pix_d;
            ferr_cnt_q <= ferr_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign joy           = joy_q;
    assign joy_upd       = joy_upd_q;
    assign osd_en        = osd_en_q;
    assign osd_rgb       = osd_rgb_q;
    assign osd_pix_valid = pix_q;
    assign frame_err_cnt = ferr_cnt_q;
    assign bad_cmd_cnt   = bad_cnt_q;
    assign timeout_cnt   = to_cnt_q;

endmodule
